// File: rtl/definitions_pkg.sv
// Shared definitions for the instruction-memory loader/controller: sizing constants and
// the controller state encoding.
package definitions_pkg;

    localparam int unsigned IMEM_AW    = 10;
    localparam int unsigned IMEM_DEPTH = 1 << IMEM_AW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } ctrl_state_e;

    // States in which the core pipeline is held in reset.
    function automatic logic core_held(ctrl_state_e s);
        return (s == IDLE) || (s == LOAD) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/imem_loader_ctrl.sv
// Owns the imem port and core run/reset: streams a program image into imem from address 0,
// then releases the core and forwards fetch reads; handles halt/resume and reload.
module imem_loader_ctrl #(
    parameter int unsigned IMEM_DEPTH = definitions_pkg::IMEM_DEPTH,
    parameter int unsigned IMEM_AW    = definitions_pkg::IMEM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    input  logic               fetch_req,
    input  logic [IMEM_AW-1:0] fetch_addr,
    input  logic               halting,
    input  logic               resume,
    output logic               imem_ncs,
    output logic               imem_nwr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din,
    output logic               core_rst,
    output logic               core_en,
    output logic               load_err,
    output logic [IMEM_AW:0]   load_cnt,
    output logic [2:0]         state
);
    import definitions_pkg::*;

    localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

    ctrl_state_e        state_q, state_d;
    logic               wr_pend_q;
    logic [IMEM_AW-1:0] wr_addr_q;
    logic [31:0]        wr_data_q;
    logic [IMEM_AW-1:0] wr_ptr_q;
    logic [IMEM_AW:0]   load_cnt_q;
    logic               load_err_q;

    logic               load_clear;
    logic               accept;
    logic               overflow;

    assign accept   = ld_ready & ld_valid;
    // A word at the top address that does not close the image means the image is too big.
    assign overflow = accept & ~ld_last & (wr_ptr_q == LAST_ADDR);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_clear = 1'b0;
        ld_ready   = 1'b0;
        core_rst   = core_held(state_q);
        core_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    load_clear = 1'b1;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (ld_last) begin
                        state_d = DRAIN;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                state_d = RUN;
            end
            RUN: begin
                core_en = 1'b1;
                if (ld_start) begin
                    state_d    = LOAD;
                    load_clear = 1'b1;
                end else if (halting) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    load_clear = 1'b1;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ write register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_ptr_q   <= '0;
            load_cnt_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            wr_pend_q <= accept;
            if (accept) begin
                wr_addr_q  <= wr_ptr_q;
                wr_data_q  <= ld_data;
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                load_cnt_q <= load_cnt_q + 1'b1;
            end
            if (overflow) begin
                load_err_q <= 1'b1;
            end
            if (load_clear) begin
                wr_ptr_q   <= '0;
                load_cnt_q <= '0;
                load_err_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------ imem port mux
    always_comb begin
        imem_ncs  = 1'b1;
        imem_nwr  = 1'b1;
        imem_addr = '0;
        imem_din  = '0;
        if (wr_pend_q) begin
            imem_ncs  = 1'b0;
            imem_nwr  = 1'b0;
            imem_addr = wr_addr_q;
            imem_din  = wr_data_q;
        end else if ((state_q == RUN) && fetch_req) begin
            imem_ncs  = 1'b0;
            imem_addr = fetch_addr;
        end
    end

    assign load_err = load_err_q;
    assign load_cnt = load_cnt_q;
    assign state    = state_q;

    // DRAIN guarantees the last write retires before fetches can start.
    a_no_write_in_run: assert property (@(posedge clk) disable iff (rst)
        !(wr_pend_q && (state_q == RUN)));

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Self-checking bench for imem_loader_ctrl: cycle model checked every negedge plus directed
// literal checks of load, fetch, overflow, halt/resume/reload and reset-mid-load.
module tb_imem_loader_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_RUN   = 3;
    localparam int M_HALT  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          halting = 1'b0;
    logic          resume = 1'b0;
    logic          imem_ncs;
    logic          imem_nwr;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic          core_rst;
    logic          core_en;
    logic          load_err;
    logic [AW:0]   load_cnt;
    logic [2:0]    state;

    imem_loader_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .halting    (halting),
        .resume     (resume),
        .imem_ncs   (imem_ncs),
        .imem_nwr   (imem_nwr),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .load_err   (load_err),
        .load_cnt   (load_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: abstract state, write pointer and one pending write.
    int m_state = M_IDLE;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_err   = 0;
    bit m_pend  = 0;
    int m_paddr = 0;
    int m_pdata = 0;
    bit m_ok    = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_state = M_IDLE; m_pend = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_ok = 1;
        end else begin
            m_pend = 0;
            case (m_state)
                M_IDLE: if (ld_start) begin
                    m_state = M_LOAD; m_ptr = 0; m_cnt = 0; m_err = 0;
                end
                M_LOAD: if (ld_valid) begin
                    m_pend = 1; m_paddr = m_ptr; m_pdata = ld_data; m_cnt++;
                    if (ld_last) begin
                        m_ptr++; m_state = M_DRAIN;
                    end else if (m_ptr == DEPTH - 1) begin
                        m_err = 1; m_ptr = 0; m_state = M_IDLE;
                    end else begin
                        m_ptr++;
                    end
                end
                M_DRAIN: m_state = M_RUN;
                M_RUN: begin
                    if (ld_start) begin
                        m_state = M_LOAD; m_ptr = 0; m_cnt = 0; m_err = 0;
                    end else if (halting) begin
                        m_state = M_HALT;
                    end
                end
                M_HALT: begin
                    if (ld_start) begin
                        m_state = M_LOAD; m_ptr = 0; m_cnt = 0; m_err = 0;
                    end else if (resume) begin
                        m_state = M_RUN;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    // Compare process plus a count of imem writes seen on the port.
    int wr_seen      = 0;
    int last_wr_addr = -1;

    initial forever begin
        bit e_fetch;
        @(negedge clk);
        if (m_ok) begin
            e_fetch = !m_pend && (m_state == M_RUN) && fetch_req;
            check("m_state",    state,    m_state);
            check("m_ld_ready", ld_ready, m_state == M_LOAD);
            check("m_core_rst", core_rst, m_state <= M_DRAIN);
            check("m_core_en",  core_en,  m_state == M_RUN);
            check("m_load_err", load_err, m_err);
            check("m_load_cnt", load_cnt, m_cnt);
            check("m_ncs",      imem_ncs, !(m_pend || e_fetch));
            check("m_nwr",      imem_nwr, !m_pend);
            check("m_addr",     imem_addr,
                  m_pend ? m_paddr : (e_fetch ? int'(fetch_addr) : 0));
            check("m_din",      imem_din, m_pend ? m_pdata : 0);
        end
        if (imem_ncs === 1'b0 && imem_nwr === 1'b0) begin
            wr_seen++;
            last_wr_addr = int'(imem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'(base + i);
            ld_last  = (i == n - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        int base;
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;

        // Reset held for two cycles.
        tick();
        tick();
        check("rst_state",    state,     3'd0);
        check("rst_core_rst", core_rst,  1'b1);
        check("rst_core_en",  core_en,   1'b0);
        check("rst_ld_ready", ld_ready,  1'b0);
        check("rst_ncs",      imem_ncs,  1'b1);
        check("rst_nwr",      imem_nwr,  1'b1);
        check("rst_addr",     imem_addr, 10'd0);
        check("rst_din",      imem_din,  32'd0);
        check("rst_cnt",      load_cnt,  11'd0);
        check("rst_err",      load_err,  1'b0);
        rst = 1'b0;
        tick();

        // 4-word load.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("load_state", state, 3'd1);
        check("load_ready", ld_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = (i == 3);
            tick();
            check("wr_ncs",  imem_ncs,  1'b0);
            check("wr_nwr",  imem_nwr,  1'b0);
            check("wr_addr", imem_addr, 10'(i));
            check("wr_din",  imem_din,  words[i]);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("drain_state",   state,    3'd2);
        check("drain_core_rst", core_rst, 1'b1);
        tick();
        check("run_state",    state,    3'd3);
        check("run_core_rst", core_rst, 1'b0);
        check("run_core_en",  core_en,  1'b1);
        check("run_ncs_idle", imem_ncs, 1'b1);
        check("run_cnt",      load_cnt, 11'd4);

        // Fetch path is combinational.
        fetch_req  = 1'b1;
        fetch_addr = 10'h2A0;
        #1;
        check("fetch_ncs",  imem_ncs,  1'b0);
        check("fetch_nwr",  imem_nwr,  1'b1);
        check("fetch_addr", imem_addr, 10'h2A0);
        check("fetch_din",  imem_din,  32'd0);
        fetch_req = 1'b0;
        #1;
        check("nofetch_ncs", imem_ncs, 1'b1);
        tick();

        // Halt, halting ignored while halted, resume.
        halting = 1'b1;
        tick();
        check("halt_state",   state,   3'd4);
        check("halt_core_en", core_en, 1'b0);
        tick();
        check("halt_stays", state, 3'd4);
        halting = 1'b0;
        resume  = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_state", state, 3'd3);

        // halting and ld_start together in RUN: reload wins.
        halting  = 1'b1;
        ld_start = 1'b1;
        tick();
        halting  = 1'b0;
        ld_start = 1'b0;
        check("reload_state",    state,    3'd1);
        check("reload_core_rst", core_rst, 1'b1);
        check("reload_ready",    ld_ready, 1'b1);
        check("reload_cnt",      load_cnt, 11'd0);

        // Overflow: offer 1025 words with no last.
        base = wr_seen;
        for (int i = 0; i < DEPTH + 1; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'(32'hA000 + i);
            ld_last  = 1'b0;
            tick();
        end
        ld_valid = 1'b0;
        check("ovf_writes",    wr_seen - base, 64'd1024);
        check("ovf_last_addr", last_wr_addr,   64'd1023);
        check("ovf_err",       load_err,       1'b1);
        check("ovf_state",     state,          3'd0);
        check("ovf_cnt",       load_cnt,       11'd1024);
        tick();

        // Full 1024-word image with last on the final word.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("full_err_clr", load_err, 1'b0);
        load_image(DEPTH, 32'hB000);
        tick();
        check("full_state", state,    3'd3);
        check("full_err",   load_err, 1'b0);
        check("full_cnt",   load_cnt, 11'd1024);

        // Reload from HALT.
        halting = 1'b1;
        tick();
        halting = 1'b0;
        check("halt2_state", state, 3'd4);
        ld_start = 1'b1;
        resume   = 1'b1;
        tick();
        ld_start = 1'b0;
        resume   = 1'b0;
        check("halt_reload_state", state, 3'd1);

        // Reset on the cycle a word is accepted drops the write.
        ld_valid = 1'b1;
        ld_data  = 32'h55;
        rst      = 1'b1;
        tick();
        ld_valid = 1'b0;
        rst      = 1'b0;
        check("rstload_ncs",   imem_ncs, 1'b1);
        check("rstload_state", state,    3'd0);
        check("rstload_cnt",   load_cnt, 11'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
